// File: rtl/otprom_cell_array_pkg.sv
// -----------------------------------------------------------------------------
// otprom_cell_array_pkg
//   Shared constants and types for the OTP PROM macro and its controller.
//   OTP_SDD_WORD locates secure_debug_disable (byte address 'h10, bit 0).
// -----------------------------------------------------------------------------
package otprom_cell_array_pkg;

  localparam int unsigned OTP_BUS_WIDTH   = 32;
  localparam int unsigned OTP_DATA_WIDTH  = 32;
  localparam int unsigned OTP_DEPTH       = 64;
  localparam int unsigned OTP_LOCK_WORD   = 63;
  localparam int unsigned OTP_SDD_WORD    = 4;
  localparam int unsigned OTP_BURN_CYCLES = 8;

  typedef enum logic {
    OTP_ST_IDLE = 1'b0,
    OTP_ST_BURN = 1'b1
  } otp_state_e;

endpackage

// File: rtl/otprom_cell_array_if.sv
// -----------------------------------------------------------------------------
// otprom_cell_array_if
//   Boot-agent side s_ram_* port of the OTP PROM.
//   master : boot agent (drives read/burn requests)
//   slave  : OTP macro  (returns read data and burn status)
//   Signals: ram_raddr/ram_ren/ram_rdata  read channel, 1-cycle latency
//            ram_waddr/ram_wdata/ram_wen  burn channel (wen = byte enables)
//            busy, burn_err, locked       controller status
// -----------------------------------------------------------------------------
interface otprom_cell_array_if
  import otprom_cell_array_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = OTP_BUS_WIDTH,
  parameter int unsigned DATA_WIDTH = OTP_DATA_WIDTH
);

  logic [BUS_WIDTH-1:0]    ram_raddr;
  logic                    ram_ren;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [BUS_WIDTH-1:0]    ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH/8-1:0] ram_wen;
  logic                    busy;
  logic                    burn_err;
  logic                    locked;

  modport master (
    output ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    input  ram_rdata, busy, burn_err, locked
  );

  modport slave (
    input  ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    output ram_rdata, busy, burn_err, locked
  );

endinterface

// File: rtl/otprom_cell_array_otp_burn_timer.sv
// -----------------------------------------------------------------------------
// otp_burn_timer
//   Loadable down-counter that times one burn.
//   clk, reset : clock, asynchronous active-high reset
//   load       : start a new interval of CYCLES cycles
//   busy       : interval in progress
//   done       : last cycle of the interval (count has reached 0)
// -----------------------------------------------------------------------------
module otp_burn_timer #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = CNT_W'(CYCLES - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy = run_q;
  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/otprom_cell_array.sv
// -----------------------------------------------------------------------------
// otprom_cell_array
//   Behavioural OTP PROM macro with burn controller. Cells start at 0 and can
//   only be burned to 1; the array itself is never reset, so burned bits
//   persist across resets.
//   clk, reset : clock, asynchronous active-high reset (array excluded)
//   bus        : slave side of otprom_cell_array_if
//                reads  -> ram_rdata registered one cycle after ram_ren
//                burns  -> busy for BURN_CYCLES cycles, then cell |= mask
//                burn_err sticky until reset; locked = cell[LOCK_WORD][0]
// -----------------------------------------------------------------------------
module otprom_cell_array
  import otprom_cell_array_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = OTP_BUS_WIDTH,
  parameter int unsigned DATA_WIDTH  = OTP_DATA_WIDTH,
  parameter int unsigned DEPTH       = OTP_DEPTH,
  parameter int unsigned BURN_CYCLES = OTP_BURN_CYCLES,
  parameter int unsigned LOCK_WORD   = OTP_LOCK_WORD
) (
  input  logic               clk,
  input  logic               reset,
  otprom_cell_array_if.slave bus
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = BUS_WIDTH - 2;

  // Cell array: no reset; powers up blank.
  logic [DATA_WIDTH-1:0] cell_q [DEPTH] = '{default: '0};

  // Address decode. Full word index is kept so that addresses above the
  // array decode as out-of-range instead of aliasing onto low words.
  logic [WIDX_W-1:0] rword, wword;
  logic [IDX_W-1:0]  ridx, widx;
  logic              r_in, w_in;
  logic              unused_addr_lsbs;

  assign rword = bus.ram_raddr[BUS_WIDTH-1:2];
  assign wword = bus.ram_waddr[BUS_WIDTH-1:2];
  assign ridx  = rword[IDX_W-1:0];
  assign widx  = wword[IDX_W-1:0];
  assign r_in  = rword < WIDX_W'(DEPTH);
  assign w_in  = wword < WIDX_W'(DEPTH);
  assign unused_addr_lsbs = ^{bus.ram_raddr[1:0], bus.ram_waddr[1:0]};

  // Burn mask: data bits qualified by their byte enables.
  logic [DATA_WIDTH-1:0] wen_exp;
  logic [DATA_WIDTH-1:0] bmask;
  logic                  wen_any;

  always_comb begin
    wen_exp = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      wen_exp[b*8 +: 8] = {8{bus.ram_wen[b]}};
    end
  end

  assign bmask   = bus.ram_wdata & wen_exp;
  assign wen_any = |bus.ram_wen;

  logic locked;
  assign locked = cell_q[LOCK_WORD][0];

  // Burn timer
  logic tmr_load, tmr_done, unused_tmr_busy;

  otp_burn_timer #(
    .CYCLES (BURN_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .busy  (unused_tmr_busy),
    .done  (tmr_done)
  );

  // Controller state
  otp_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] bmask_q, bmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  commit;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    bidx_d   = bidx_q;
    bmask_d  = bmask_q;
    tmr_load = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      OTP_ST_IDLE: begin
        if (wen_any) begin
          if (locked || !w_in) begin
            err_d = 1'b1;
          end else if (bmask != '0) begin
            bidx_d   = widx;
            bmask_d  = bmask;
            tmr_load = 1'b1;
            state_d  = OTP_ST_BURN;
          end
        end
      end
      OTP_ST_BURN: begin
        // Requests arriving mid-burn are dropped, never queued.
        if (wen_any) begin
          err_d = 1'b1;
        end
        if (tmr_done) begin
          commit  = 1'b1;
          state_d = OTP_ST_IDLE;
        end
      end
      default: state_d = OTP_ST_IDLE;
    endcase
  end

  assign busy_d = (state_d == OTP_ST_BURN);

  // Reads sample the array before this edge's commit, so a read in the
  // commit cycle still returns pre-burn contents.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.ram_ren) begin
      rdata_d = r_in ? cell_q[ridx] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OTP_ST_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      bidx_q  <= '0;
      bmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      bidx_q  <= bidx_d;
      bmask_q <= bmask_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit only ORs bits in; a reset mid-burn returns state to IDLE so the
  // pending mask is never applied.
  always_ff @(posedge clk) begin
    if (commit) begin
      cell_q[bidx_q] <= cell_q[bidx_q] | bmask_q;
    end
  end

  assign bus.ram_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.burn_err  = err_q;
  assign bus.locked    = locked;

endmodule
